// File: rtl/arith_kind_decoder.sv
// Purpose : decodes a bundle of LANES RISC-V arithmetic instructions (OP-IMM, OP and,
//           with RV64=1, OP-IMM-32/OP-32) into operation kinds, flags and shift amounts.
// Latency : a bundle accepted at edge N is on the outputs right after edge N.
// Backpr. : 2-entry skid buffer; in_ready is registered (next occupancy < 2), so a
//           full buffer blocks the push even when out_ready is high that cycle.
// Ports   : clk/rst (async, active-high), flush (sync buffer clear),
//           in_valid/in_ready/in_lane_valid/in_instr (producer side),
//           out_valid/out_ready/out_lane_valid/out_kind/out_is_imm/out_is_word/
//           out_illegal/out_shamt (head bundle), illegal_count (saturating 16-bit).
module arith_kind_decoder #(
  parameter int LANES = 2,
  parameter bit RV64  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES-1:0]     in_lane_valid,
  input  logic [32*LANES-1:0]  in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_lane_valid,
  output logic [5*LANES-1:0]   out_kind,
  output logic [LANES-1:0]     out_is_imm,
  output logic [LANES-1:0]     out_is_word,
  output logic [LANES-1:0]     out_illegal,
  output logic [6*LANES-1:0]   out_shamt,
  output logic [15:0]          illegal_count
);

  typedef enum logic [4:0] {
    KIND_INVALID = 5'd0,
    KIND_ADD     = 5'd1,
    KIND_SUB     = 5'd2,
    KIND_SLL     = 5'd3,
    KIND_SLT     = 5'd4,
    KIND_SLTU    = 5'd5,
    KIND_XOR     = 5'd6,
    KIND_SRL     = 5'd7,
    KIND_SRA     = 5'd8,
    KIND_OR      = 5'd9,
    KIND_AND     = 5'd10
  } arith_kind_t;

  typedef struct packed {
    arith_kind_t kind;
    logic        is_imm;
    logic        is_word;
    logic        illegal;
    logic [5:0]  shamt;
  } lane_dec_t;

  typedef struct packed {
    logic [LANES-1:0]   lane_valid;
    logic [5*LANES-1:0] kind;
    logic [LANES-1:0]   is_imm;
    logic [LANES-1:0]   is_word;
    logic [LANES-1:0]   illegal;
    logic [6*LANES-1:0] shamt;
  } bundle_t;

  // Register-register rules shared by OP and OP-32. Returns {bad, kind}.
  function automatic logic [5:0] op_rules(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic word);
    logic        bad;
    arith_kind_t k;
    bad = 1'b0;
    k   = KIND_INVALID;
    if (f7 == 7'b0000000) begin
      case (f3)
        3'b000:  k = KIND_ADD;
        3'b001:  k = KIND_SLL;
        3'b010:  k = KIND_SLT;
        3'b011:  k = KIND_SLTU;
        3'b100:  k = KIND_XOR;
        3'b101:  k = KIND_SRL;
        3'b110:  k = KIND_OR;
        default: k = KIND_AND;
      endcase
    end else if (f7 == 7'b0100000) begin
      case (f3)
        3'b000:  k = KIND_SUB;
        3'b101:  k = KIND_SRA;
        default: bad = 1'b1;
      endcase
    end else begin
      bad = 1'b1;
    end
    // W-forms only exist for add/sub and the shifts.
    if (word && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) bad = 1'b1;
    return {bad, k};
  endfunction

  function automatic lane_dec_t decode_lane(input logic [31:0] ins);
    lane_dec_t  d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       sh_zero;
    logic       sh_alt;
    logic       bad;
    logic [5:0] r;
    f3  = ins[14:12];
    f7  = ins[31:25];
    // RV64 immediate shifts use bit 25 as shamt[5], so only funct6 is checked there.
    sh_zero = RV64 ? (ins[31:26] == 6'b000000) : (f7 == 7'b0000000);
    sh_alt  = RV64 ? (ins[31:26] == 6'b010000) : (f7 == 7'b0100000);
    d   = '0;
    bad = 1'b0;
    r   = '0;
    case (ins[6:0])
      7'b0010011: begin
        d.is_imm = 1'b1;
        case (f3)
          3'b000: d.kind = KIND_ADD;
          3'b010: d.kind = KIND_SLT;
          3'b011: d.kind = KIND_SLTU;
          3'b100: d.kind = KIND_XOR;
          3'b110: d.kind = KIND_OR;
          3'b111: d.kind = KIND_AND;
          3'b001: begin
            d.kind  = KIND_SLL;
            d.shamt = {RV64 & ins[25], ins[24:20]};
            bad     = !sh_zero;
          end
          default: begin
            d.shamt = {RV64 & ins[25], ins[24:20]};
            if (sh_zero)     d.kind = KIND_SRL;
            else if (sh_alt) d.kind = KIND_SRA;
            else             bad = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        r      = op_rules(f3, f7, 1'b0);
        bad    = r[5];
        d.kind = arith_kind_t'(r[4:0]);
      end
      7'b0011011: begin
        if (RV64) begin
          d.is_imm  = 1'b1;
          d.is_word = 1'b1;
          // Full funct7 compare also enforces shamt[5] == 0 for the W shifts.
          case (f3)
            3'b000: d.kind = KIND_ADD;
            3'b001: begin
              d.shamt = {1'b0, ins[24:20]};
              if (f7 == 7'b0000000) d.kind = KIND_SLL;
              else                  bad = 1'b1;
            end
            3'b101: begin
              d.shamt = {1'b0, ins[24:20]};
              if (f7 == 7'b0000000)      d.kind = KIND_SRL;
              else if (f7 == 7'b0100000) d.kind = KIND_SRA;
              else                       bad = 1'b1;
            end
            default: bad = 1'b1;
          endcase
        end
      end
      7'b0111011: begin
        if (RV64) begin
          d.is_word = 1'b1;
          r         = op_rules(f3, f7, 1'b1);
          bad       = r[5];
          d.kind    = arith_kind_t'(r[4:0]);
        end
      end
      default: d = '0;
    endcase
    if (bad) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [5*LANES-1:0] dec_kind;
  logic [LANES-1:0]   dec_is_imm;
  logic [LANES-1:0]   dec_is_word;
  logic [LANES-1:0]   dec_illegal;
  logic [6*LANES-1:0] dec_shamt;
  bundle_t            dec_bundle;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_dec_t d;
    assign d = in_lane_valid[g] ? decode_lane(in_instr[32*g +: 32]) : '0;
    assign dec_kind[5*g +: 5]  = d.kind;
    assign dec_is_imm[g]       = d.is_imm;
    assign dec_is_word[g]      = d.is_word;
    assign dec_illegal[g]      = d.illegal;
    assign dec_shamt[6*g +: 6] = d.shamt;
  end

  assign dec_bundle = '{lane_valid: in_lane_valid, kind: dec_kind, is_imm: dec_is_imm,
                        is_word: dec_is_word, illegal: dec_illegal, shamt: dec_shamt};

  // ---------------------------------------------------------------- buffer
  bundle_t    mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic       in_ready_q;
  logic [15:0] cnt_q, cnt_d;
  logic       push, pop;
  logic [2:0] ill_pop;
  logic [16:0] cnt_sum;

  // Flush wins over both handshakes in the same cycle.
  assign push = in_valid && in_ready_q && !flush;
  assign pop  = (occ_q != 2'd0) && out_ready && !flush;

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      occ_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_comb begin
    ill_pop = '0;
    for (int i = 0; i < LANES; i++) ill_pop = ill_pop + {2'b00, dec_illegal[i]};
    cnt_sum = {1'b0, cnt_q} + {14'd0, ill_pop};
    cnt_d   = cnt_q;
    if (push) cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= dec_bundle;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= (occ_d < 2'd2);
      cnt_q      <= cnt_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  bundle_t head;
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (occ_q != 2'd0);
  assign in_ready  = in_ready_q;

  // Fields read as zero whenever the buffer is empty (reset, flush, drained).
  assign out_lane_valid = out_valid ? head.lane_valid : '0;
  assign out_kind       = out_valid ? head.kind       : '0;
  assign out_is_imm     = out_valid ? head.is_imm     : '0;
  assign out_is_word    = out_valid ? head.is_word    : '0;
  assign out_illegal    = out_valid ? head.illegal    : '0;
  assign out_shamt      = out_valid ? head.shamt      : '0;
  assign illegal_count  = cnt_q;

endmodule
